// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter for four requesters sharing one FIFO port.
// A granted owner keeps the port for up to BURST beats before rotation.
module fifo_wr_arb #(
  parameter int unsigned BURST = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  input  logic [7:0]  req_data2,
  input  logic [7:0]  req_data3,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  input  logic        fifo_rd,
  output logic        fifo_wr,
  output logic [7:0]  fifo_wr_data,
  output logic [3:0]  gnt,
  output logic        locked,
  output logic [1:0]  owner,
  output logic [15:0] accept_cnt
);

  localparam logic [3:0] BURST_B = 4'(BURST);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } st_e;

  st_e         st_q, st_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  own_q, own_d;
  logic [3:0]  beats_q, beats_d;
  logic [15:0] cnt_q, cnt_d;

  logic        slot;
  logic [1:0]  start;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  idx;
  logic [3:0]  beats_inc;

  // A pending consumer read takes the FIFO's single operation slot.
  assign slot = !fifo_full && !(fifo_rd && !fifo_empty);

  assign start = (st_q == LOCK) ? own_q + 2'd1 : ptr_q;
  assign beats_inc = beats_q + 4'd1;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    beats_d = beats_q;
    gnt     = 4'b0000;
    if (!rst) begin
      if (st_q == LOCK && req[own_q]) begin
        if (slot) begin
          gnt[own_q] = 1'b1;
          beats_d    = beats_inc;
          if (beats_inc == BURST_B) begin
            st_d    = IDLE;
            ptr_d   = own_q + 2'd1;
            beats_d = 4'd0;
          end
        end
      end else if (slot && pick_vld) begin
        gnt[pick_idx] = 1'b1;
        if (BURST == 1) begin
          st_d    = IDLE;
          ptr_d   = pick_idx + 2'd1;
          beats_d = 4'd0;
        end else begin
          st_d    = LOCK;
          own_d   = pick_idx;
          beats_d = 4'd1;
        end
      end else if (st_q == LOCK) begin
        // Owner dropped and nobody else could be granted.
        st_d    = IDLE;
        ptr_d   = own_q + 2'd1;
        beats_d = 4'd0;
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      gnt[0]:  fifo_wr_data = req_data0;
      gnt[1]:  fifo_wr_data = req_data1;
      gnt[2]:  fifo_wr_data = req_data2;
      gnt[3]:  fifo_wr_data = req_data3;
      default: fifo_wr_data = 8'h00;
    endcase
  end

  assign fifo_wr = |gnt;
  assign cnt_d   = cnt_q + 16'(fifo_wr);

  always_ff @(posedge clock) begin
    if (rst) begin
      st_q    <= IDLE;
      ptr_q   <= 2'd0;
      own_q   <= 2'd0;
      beats_q <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked     = (st_q == LOCK);
  assign owner      = locked ? own_q : 2'd0;
  assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: BURST=4 and BURST=1 instances
// share stimulus; a behavioural model predicts each cycle's outputs.
module tb_fifo_wr_arb;

  logic        clock;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  dat [4];
  logic        fifo_full, fifo_empty, fifo_rd;

  logic        wr4, wr1;
  logic [7:0]  wd4, wd1;
  logic [3:0]  g4, g1;
  logic        lk4, lk1;
  logic [1:0]  ow4, ow1;
  logic [15:0] cn4, cn1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ptr; int own; bit lk; int beats; int cnt;
  } ms_t;

  typedef struct {
    logic [3:0] gnt; logic wr; logic [7:0] data;
    logic lk; logic [1:0] own; logic [15:0] cnt;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  ms_t  m4, m1;
  logic [7:0] nd [4];
  logic [3:0] last_g;

  fifo_wr_arb #(.BURST(4)) dut4 (
    .clock(clock), .rst(rst), .req(req),
    .req_data0(dat[0]), .req_data1(dat[1]),
    .req_data2(dat[2]), .req_data3(dat[3]),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_wr(wr4),
    .fifo_wr_data(wd4), .gnt(g4), .locked(lk4),
    .owner(ow4), .accept_cnt(cn4)
  );

  fifo_wr_arb #(.BURST(1)) dut1 (
    .clock(clock), .rst(rst), .req(req),
    .req_data0(dat[0]), .req_data1(dat[1]),
    .req_data2(dat[2]), .req_data3(dat[3]),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .fifo_wr(wr1),
    .fifo_wr_data(wd1), .gnt(g1), .locked(lk1),
    .owner(ow1), .accept_cnt(cn1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: owner keeps port while requesting, else rotate.
  function automatic void mstep(
    input int B, input ms_t mi, output ms_t mo, output exp_t e
  );
    int g;
    int s;
    bit slot;
    mo = mi;
    g = -1;
    slot = !fifo_full && !(fifo_rd && !fifo_empty);
    e.lk  = mi.lk;
    e.own = mi.lk ? 2'(mi.own) : 2'd0;
    e.cnt = 16'(mi.cnt);
    if (rst) begin
      mo = '{0, 0, 1'b0, 0, 0};
    end else if (mi.lk && req[mi.own]) begin
      if (slot) begin
        g = mi.own;
        mo.beats = mi.beats + 1;
        if (mo.beats == B) begin
          mo.lk = 1'b0;
          mo.ptr = (mi.own + 1) % 4;
          mo.beats = 0;
        end
      end
    end else begin
      s = mi.lk ? (mi.own + 1) % 4 : mi.ptr;
      if (slot)
        for (int k = 0; k < 4; k++)
          if (g < 0 && req[(s + k) % 4]) g = (s + k) % 4;
      if (g >= 0) begin
        if (B == 1) begin
          mo.ptr = (g + 1) % 4;
        end else begin
          mo.lk = 1'b1;
          mo.own = g;
          mo.beats = 1;
        end
      end else if (mi.lk) begin
        mo.lk = 1'b0;
        mo.ptr = (mi.own + 1) % 4;
        mo.beats = 0;
      end
    end
    if (g >= 0) mo.cnt = (mi.cnt + 1) % 65536;
    e.gnt  = (g >= 0) ? 4'(1 << g) : 4'b0000;
    e.wr   = (g >= 0);
    e.data = (g >= 0) ? dat[g] : 8'h00;
  endfunction

  task automatic apply(
    input bit r, input logic [3:0] rq,
    input bit f, input bit em, input bit rd
  );
    exp_t e4, e1;
    ms_t n4, n1;
    @(negedge clock);
    rst = r;
    req = rq;
    fifo_full = f;
    fifo_empty = em;
    fifo_rd = rd;
    for (int i = 0; i < 4; i++) dat[i] = nd[i];
    #1;
    mstep(4, m4, n4, e4);
    mstep(1, m1, n1, e1);
    m4 = n4;
    m1 = n1;
    q4.push_back(e4);
    q1.push_back(e1);
    last_g = e4.gnt;
  endtask

  task automatic chk(
    input string nm, input logic [15:0] act, input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cmp(
    input string nm, input exp_t e,
    input logic [3:0] g, input logic w, input logic [7:0] d,
    input logic l, input logic [1:0] o, input logic [15:0] c
  );
    checks++;
    if (g !== e.gnt || w !== e.wr || d !== e.data ||
        l !== e.lk || o !== e.own || c !== e.cnt) begin
      failures++;
      $display("FAIL %s t=%0t got gnt=%b wr=%b d=%h lk=%b own=%0d cnt=%h want gnt=%b wr=%b d=%h lk=%b own=%0d cnt=%h",
               nm, $time, g, w, d, l, o, c,
               e.gnt, e.wr, e.data, e.lk, e.own, e.cnt);
    end
  endtask

  always @(negedge clock) begin
    #3;
    if (q4.size() > 0) cmp("b4", q4.pop_front(), g4, wr4, wd4, lk4, ow4, cn4);
    if (q1.size() > 0) cmp("b1", q1.pop_front(), g1, wr1, wd1, lk1, ow1, cn1);
  end

  task automatic rnd_data();
    for (int i = 0; i < 4; i++) nd[i] = 8'($urandom);
  endtask

  initial begin
    logic [3:0] rq;
    rst = 1'b1;
    req = 4'b0;
    fifo_full = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dat[i] = 8'h00;
      nd[i] = 8'h00;
    end
    m4 = '{0, 0, 1'b0, 0, 0};
    m1 = '{0, 0, 1'b0, 0, 0};
    last_g = 4'b0;

    // Reset with active requests: nothing may be granted.
    rnd_data();
    apply(1, 4'b1111, 0, 1, 0);
    apply(1, 4'b1111, 0, 0, 1);
    apply(1, 4'b0110, 0, 1, 0);

    // Full request set, open slot: bursts of four rotate.
    for (int c = 0; c < 17; c++) begin
      rnd_data();
      apply(0, 4'b1111, 0, 1, 0);
      if (c == 15) begin
        @(posedge clock); #1;
        chk("cnt16_b4", cn4, 16'd16);
        chk("cnt16_b1", cn1, 16'd16);
      end
    end

    // Blocked owner mid-burst, then owner drop and full flag.
    apply(1, 4'b0000, 0, 1, 0);
    apply(0, 4'b0100, 0, 1, 0);
    apply(0, 4'b0100, 0, 1, 0);
    for (int c = 0; c < 3; c++) apply(0, 4'b1111, 0, 0, 1);
    apply(0, 4'b0100, 0, 1, 0);
    apply(0, 4'b0100, 0, 1, 0);
    apply(0, 4'b1111, 0, 1, 0);
    apply(0, 4'b0010, 0, 1, 0);
    apply(0, 4'b1001, 0, 1, 0);
    apply(0, 4'b0110, 1, 1, 0);
    apply(0, 4'b0110, 1, 0, 1);
    apply(0, 4'b0110, 0, 1, 0);

    // Random traffic; requests held until granted.
    rq = 4'b0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rq[i] && last_g[i]) begin
          rq[i] = ($urandom_range(0, 1) == 1);
          nd[i] = 8'($urandom);
        end else if (!rq[i] && $urandom_range(0, 9) < 4) begin
          rq[i] = 1'b1;
          nd[i] = 8'($urandom);
        end
      end
      apply(0, rq,
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 3);
    end

    // Reset in the middle of a burst.
    apply(0, 4'b1111, 0, 1, 0);
    apply(0, 4'b1111, 0, 1, 0);
    apply(1, 4'b1111, 0, 1, 0);
    @(posedge clock); #1;
    chk("rst_locked", 16'(lk4), 16'd0);
    chk("rst_gnt", 16'(g4), 16'd0);
    apply(1, 4'b1111, 0, 1, 0);
    apply(0, 4'b1110, 0, 1, 0);
    apply(0, 4'b1111, 0, 1, 0);

    // Counter wrap from a clean reset.
    apply(1, 4'b0000, 0, 1, 0);
    for (int c = 0; c < 65535; c++) apply(0, 4'b0001, 0, 1, 0);
    @(posedge clock); #1;
    chk("cnt_ffff", cn4, 16'hFFFF);
    apply(0, 4'b0001, 0, 1, 0);
    @(posedge clock); #1;
    chk("cnt_wrap", cn4, 16'h0000);
    chk("cnt_wrap1", cn1, 16'h0000);

    apply(0, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 10 && (q4.size() > 0 || q1.size() > 0); i++)
      @(negedge clock);
    #5;
    if (q4.size() > 0 || q1.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain left=%0d want=0", q4.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
